// File: rtl/tx_pkt_arbiter.sv
// tx_pkt_arbiter: shares the USB full-speed PHY transmit byte interface
// between two requesters. The grant is held for a whole packet, then the line
// must go idle (PHY tx_en low) and a programmable inter-packet gap must elapse
// before the next grant. All state advances only on clk_gate_i (one per bit).
//
// Optional build macro: TX_ARB_RR_EN
//   defined   -> round-robin on simultaneous requests (1-bit last-owner pointer)
//   undefined -> fixed priority, req0 wins ties
//
// state  | meaning
// IDLE   | no owner; grant the winner at the next gate with any request
// ACTIVE | bytes forwarded combinationally from the owner to the PHY
// DRAIN  | packet ended or aborted; wait for PHY tx_en to fall
// GAP    | counting the inter-packet gap down to zero

module tx_pkt_arbiter #(
  parameter int unsigned IPG_BITS = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       clk_gate_i,
  input  logic       req0_valid_i,
  input  logic [7:0] req0_data_i,
  input  logic       req0_last_i,
  output logic       req0_ready_o,
  input  logic       req1_valid_i,
  input  logic [7:0] req1_data_i,
  input  logic       req1_last_i,
  output logic       req1_ready_o,
  output logic       phy_tx_valid_o,
  output logic [7:0] phy_tx_data_o,
  input  logic       phy_tx_ready_i,
  input  logic       phy_tx_en_i,
  output logic [1:0] grant_o,
  output logic       busy_o,
  output logic       abort_o
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN, S_GAP} state_t;

  state_t           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             abort_q, abort_d;
`ifdef TX_ARB_RR_EN
  logic             rr_q, rr_d;
`endif

  logic       active;
  logic       g_valid;
  logic [7:0] g_data;
  logic       g_last;
  logic       win1;
  logic       consume;

  // Owner-side mux and combinational forwarding while ACTIVE.
  always_comb begin
    active         = (state_q == S_ACTIVE);
    g_valid        = grant_q[1] ? req1_valid_i : req0_valid_i;
    g_data         = grant_q[1] ? req1_data_i  : req0_data_i;
    g_last         = grant_q[1] ? req1_last_i  : req0_last_i;
    phy_tx_valid_o = active & g_valid;
    phy_tx_data_o  = active ? g_data : 8'h00;
    req0_ready_o   = active & grant_q[0] & phy_tx_ready_i & req0_valid_i;
    req1_ready_o   = active & grant_q[1] & phy_tx_ready_i & req1_valid_i;
    consume        = clk_gate_i & phy_tx_ready_i & phy_tx_valid_o;
    grant_o        = grant_q;
    busy_o         = (state_q != S_IDLE);
    abort_o        = abort_q;
  end

  // Arbitration winner; win1 = 1 selects req1. Only meaningful with a request.
  always_comb begin
`ifdef TX_ARB_RR_EN
    if (req0_valid_i && req1_valid_i) win1 = ~rr_q;
    else                              win1 = req1_valid_i;
`else
    win1 = ~req0_valid_i;
`endif
  end

  // Next-state logic; nothing moves unless clk_gate_i is high.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    abort_d = abort_q;
`ifdef TX_ARB_RR_EN
    rr_d    = rr_q;
`endif
    if (clk_gate_i) begin
      // abort is a single bit-time pulse
      abort_d = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req0_valid_i || req1_valid_i) begin
            grant_d = win1 ? 2'b10 : 2'b01;
            state_d = S_ACTIVE;
`ifdef TX_ARB_RR_EN
            rr_d    = win1;
`endif
          end
        end
        S_ACTIVE: begin
          if (!g_valid) begin
            abort_d = 1'b1;
            state_d = S_DRAIN;
          end else if (consume && g_last) begin
            state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!phy_tx_en_i) begin
            cnt_d   = CNT_W'(IPG_BITS - 1);
            state_d = S_GAP;
          end
        end
        S_GAP: begin
          if (cnt_q == '0) begin
            grant_d = 2'b00;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          grant_d = 2'b00;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      grant_q <= 2'b00;
      cnt_q   <= '0;
      abort_q <= 1'b0;
`ifdef TX_ARB_RR_EN
      rr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
`ifdef TX_ARB_RR_EN
      rr_q    <= rr_d;
`endif
    end
  end

endmodule
